// File: rtl/asym_ram_pkg.sv
// Shared types and elaboration helpers for the asymmetric true-dual-port RAM.
package asym_ram_pkg;

  typedef enum logic [1:0] {WRITE_FIRST, READ_FIRST, NO_CHANGE} ram_mode_e;

  // log2 of the wide/narrow width ratio; returns 0 for equal widths.
  function automatic int unsigned ratioLog2(int unsigned wa, int unsigned wb);
    int unsigned r;
    int unsigned l;
    r = (wa > wb) ? wa / wb : wb / wa;
    l = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(r)) l = i + 1;
    return l;
  endfunction

  function automatic bit ramParamsLegal(int unsigned wa, int unsigned awa,
                                        int unsigned wb, int unsigned awb);
    int unsigned hi;
    int unsigned lo;
    int unsigned r;
    hi = (wa > wb) ? wa : wb;
    lo = (wa > wb) ? wb : wa;
    if (lo == 0 || (hi % lo) != 0) return 1'b0;
    r = hi / lo;
    if ((r & (r - 1)) != 0) return 1'b0;
    return (64'(wa) << awa) == (64'(wb) << awb);
  endfunction

endpackage

// File: rtl/asym_ram_tdp_param_if.sv
// Port bundle for asym_ram_tdp_param; collision/coll_cnt exist only with
// ASYM_RAM_COLLISION_DET_EN defined.
interface asym_ram_tdp_param_if #(
  parameter int WIDTHA     = 16,
  parameter int ADDRWIDTHA = 8,
  parameter int WIDTHB     = 4,
  parameter int ADDRWIDTHB = 10
);
  logic                  enA, weA, vldA;
  logic [ADDRWIDTHA-1:0] addrA;
  logic [WIDTHA-1:0]     diA, doA;
  logic                  enB, weB, vldB;
  logic [ADDRWIDTHB-1:0] addrB;
  logic [WIDTHB-1:0]     diB, doB;
`ifdef ASYM_RAM_COLLISION_DET_EN
  logic                  collision;
  logic [15:0]           coll_cnt;
`endif

  modport master (
`ifdef ASYM_RAM_COLLISION_DET_EN
    input  collision, coll_cnt,
`endif
    output enA, weA, addrA, diA, enB, weB, addrB, diB,
    input  doA, vldA, doB, vldB
  );

  modport slave (
`ifdef ASYM_RAM_COLLISION_DET_EN
    output collision, coll_cnt,
`endif
    input  enA, weA, addrA, diA, enB, weB, addrB, diB,
    output doA, vldA, doB, vldB
  );
endinterface

// File: rtl/asym_ram_port_out.sv
// Per-port read-during-write mux, optional output register and valid pipeline.
module asym_ram_port_out
  import asym_ram_pkg::*;
#(
  parameter int        WIDTH   = 16,
  parameter ram_mode_e MODE    = WRITE_FIRST,
  parameter bit        OUT_REG = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  input  logic [WIDTH-1:0] rdOld,
  output logic [WIDTH-1:0] dout,
  output logic             vld
);
  logic [WIDTH-1:0] dataNxt, dataQ;
  logic             vldNxt, vldQ;

  always_comb begin
    vldNxt  = en;
    dataNxt = rdOld;
    if (en && we) begin
      case (MODE)
        WRITE_FIRST: dataNxt = di;
        NO_CHANGE:   vldNxt  = 1'b0;
        default:     ;
      endcase
    end
  end

  // Data only loads on a valid access so the output holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataQ <= '0;
      vldQ  <= 1'b0;
    end else begin
      vldQ <= vldNxt;
      if (vldNxt) dataQ <= dataNxt;
    end
  end

  if (OUT_REG) begin : gOutReg
    logic [WIDTH-1:0] dataQ2;
    logic             vldQ2;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dataQ2 <= '0;
        vldQ2  <= 1'b0;
      end else begin
        vldQ2 <= vldQ;
        if (vldQ) dataQ2 <= dataQ;
      end
    end
    assign dout = dataQ2;
    assign vld  = vldQ2;
  end else begin : gNoOutReg
    assign dout = dataQ;
    assign vld  = vldQ;
  end

endmodule

// File: rtl/asym_ram_tdp_param.sv
// Asymmetric true-dual-port RAM over a shared narrow-word array.
// Optional collision detector: define ASYM_RAM_COLLISION_DET_EN.
module asym_ram_tdp_param
  import asym_ram_pkg::*;
#(
  parameter int        WIDTHA     = 16,
  parameter int        ADDRWIDTHA = 8,
  parameter int        WIDTHB     = 4,
  parameter int        ADDRWIDTHB = 10,
  parameter ram_mode_e MODE       = WRITE_FIRST,
  parameter bit        OUT_REG    = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  asym_ram_tdp_param_if.slave bus
);
  localparam int unsigned NARROW = (WIDTHA < WIDTHB) ? WIDTHA : WIDTHB;
  localparam int unsigned MAXAW  = (ADDRWIDTHA > ADDRWIDTHB) ? ADDRWIDTHA : ADDRWIDTHB;
  localparam int unsigned LR     = ratioLog2(WIDTHA, WIDTHB);
  localparam int unsigned LRA    = (WIDTHA > WIDTHB) ? LR : 0;
  localparam int unsigned LRB    = (WIDTHB > WIDTHA) ? LR : 0;
  localparam int unsigned LANESA = 1 << LRA;
  localparam int unsigned LANESB = 1 << LRB;

  if (!ramParamsLegal(WIDTHA, ADDRWIDTHA, WIDTHB, ADDRWIDTHB)) begin : gIllegal
    $error("asym_ram_tdp_param: illegal width/address-width combination");
  end

  logic [NARROW-1:0] mem [1 << MAXAW];
  logic [MAXAW-1:0]  baseA, baseB;
  logic [WIDTHA-1:0] rdA;
  logic [WIDTHB-1:0] rdB;

  assign baseA = MAXAW'(bus.addrA) << LRA;
  assign baseB = MAXAW'(bus.addrB) << LRB;

  // Pre-write contents; collisions resolve to old data for the reader.
  always_comb begin
    rdA = '0;
    for (int unsigned k = 0; k < LANESA; k++)
      rdA[k*NARROW +: NARROW] = mem[baseA | MAXAW'(k)];
  end

  always_comb begin
    rdB = '0;
    for (int unsigned k = 0; k < LANESB; k++)
      rdB[k*NARROW +: NARROW] = mem[baseB | MAXAW'(k)];
  end

  // Port A commits after port B so it wins every overlapping lane.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (bus.enB && bus.weB)
        for (int unsigned k = 0; k < LANESB; k++)
          mem[baseB | MAXAW'(k)] <= bus.diB[k*NARROW +: NARROW];
      if (bus.enA && bus.weA)
        for (int unsigned k = 0; k < LANESA; k++)
          mem[baseA | MAXAW'(k)] <= bus.diA[k*NARROW +: NARROW];
    end
  end

  asym_ram_port_out #(.WIDTH(WIDTHA), .MODE(MODE), .OUT_REG(OUT_REG)) uPortA (
    .clk(clk), .rst_n(rst_n), .en(bus.enA), .we(bus.weA), .di(bus.diA),
    .rdOld(rdA), .dout(bus.doA), .vld(bus.vldA)
  );

  asym_ram_port_out #(.WIDTH(WIDTHB), .MODE(MODE), .OUT_REG(OUT_REG)) uPortB (
    .clk(clk), .rst_n(rst_n), .en(bus.enB), .we(bus.weB), .di(bus.diB),
    .rdOld(rdB), .dout(bus.doB), .vld(bus.vldB)
  );

`ifdef ASYM_RAM_COLLISION_DET_EN
  logic        collNow, collQ;
  logic [15:0] collCnt;

  // Aligned power-of-two ranges overlap exactly when their wide indices match.
  assign collNow = bus.enA && bus.enB && (bus.weA || bus.weB) &&
                   ((baseA >> LR) == (baseB >> LR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collQ   <= 1'b0;
      collCnt <= '0;
    end else begin
      collQ <= collNow;
      if (collNow && collCnt != '1) collCnt <= collCnt + 16'd1;
    end
  end

  if (OUT_REG) begin : gCollReg
    logic collQ2;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) collQ2 <= 1'b0;
      else        collQ2 <= collQ;
    end
    assign bus.collision = collQ2;
  end else begin : gCollNoReg
    assign bus.collision = collQ;
  end

  assign bus.coll_cnt = collCnt;
`endif

endmodule

// File: tb/tb_asym_ram_tdp_param.sv
// Four DUTs (WF, RF, NC, WF+OUT_REG) share one stimulus stream; a reference
// memory predicts every output cycle into per-DUT queues.
module tb_asym_ram_tdp_param;
  import asym_ram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enA, weA, enB, weB;
  logic [7:0]  addrA;
  logic [15:0] diA;
  logic [9:0]  addrB;
  logic [3:0]  diB;

  logic [15:0] doA [4];
  logic [3:0]  doB [4];
  logic        vldA [4];
  logic        vldB [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gDut
    localparam ram_mode_e M = (g == 1) ? READ_FIRST : (g == 2) ? NO_CHANGE : WRITE_FIRST;
    asym_ram_tdp_param_if #(.WIDTHA(16), .ADDRWIDTHA(8), .WIDTHB(4), .ADDRWIDTHB(10)) ifc ();
    assign ifc.enA = enA;  assign ifc.weA = weA;  assign ifc.addrA = addrA;  assign ifc.diA = diA;
    assign ifc.enB = enB;  assign ifc.weB = weB;  assign ifc.addrB = addrB;  assign ifc.diB = diB;
    assign doA[g] = ifc.doA;  assign vldA[g] = ifc.vldA;
    assign doB[g] = ifc.doB;  assign vldB[g] = ifc.vldB;
    asym_ram_tdp_param #(
      .WIDTHA(16), .ADDRWIDTHA(8), .WIDTHB(4), .ADDRWIDTHB(10),
      .MODE(M), .OUT_REG(g == 3)
    ) dut (
      .clk(clk), .rst_n(rst_n), .bus(ifc)
    );
  end

  int          nTests = 0;
  int          nFail  = 0;
  int          cyc    = 0;
  logic [3:0]  refMem [1024];
  logic [15:0] lastA [4];
  logic [3:0]  lastB [4];
  logic [16:0] qA [4][$];
  logic [4:0]  qB [4][$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ram_mode_e modeAt(int d);
    return (d == 1) ? READ_FIRST : (d == 2) ? NO_CHANGE : WRITE_FIRST;
  endfunction

  task automatic checkOutputs();
    for (int d = 0; d < 4; d++) begin
      int lat = (d == 3) ? 2 : 1;
      if (qA[d].size() >= lat) begin
        logic [16:0] e = qA[d].pop_front();
        chk($sformatf("d%0d.portA@%0d", d, cyc), 32'({vldA[d], doA[d]}), 32'(e));
      end
      if (qB[d].size() >= lat) begin
        logic [4:0] e = qB[d].pop_front();
        chk($sformatf("d%0d.portB@%0d", d, cyc), 32'({vldB[d], doB[d]}), 32'(e));
      end
    end
  endtask

  task automatic checkZero(input string tag);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s.d%0d.A", tag, d), 32'({vldA[d], doA[d]}), 32'h0);
      chk($sformatf("%s.d%0d.B", tag, d), 32'({vldB[d], doB[d]}), 32'h0);
    end
  endtask

  task automatic modelStep();
    logic [15:0] oldA;
    logic [3:0]  oldB;
    for (int k = 0; k < 4; k++) oldA[k*4 +: 4] = refMem[{addrA, 2'(k)}];
    oldB = refMem[addrB];
    for (int d = 0; d < 4; d++) begin
      ram_mode_e   m = modeAt(d);
      logic [16:0] eA;
      logic [4:0]  eB;
      if (!enA)                          eA = {1'b0, lastA[d]};
      else if (!weA || m == READ_FIRST)  eA = {1'b1, oldA};
      else if (m == WRITE_FIRST)         eA = {1'b1, diA};
      else                               eA = {1'b0, lastA[d]};
      if (!enB)                          eB = {1'b0, lastB[d]};
      else if (!weB || m == READ_FIRST)  eB = {1'b1, oldB};
      else if (m == WRITE_FIRST)         eB = {1'b1, diB};
      else                               eB = {1'b0, lastB[d]};
      if (eA[16]) lastA[d] = eA[15:0];
      if (eB[4])  lastB[d] = eB[3:0];
      qA[d].push_back(eA);
      qB[d].push_back(eB);
    end
    if (enB && weB) refMem[addrB] = diB;
    if (enA && weA)
      for (int k = 0; k < 4; k++) refMem[{addrA, 2'(k)}] = diA[k*4 +: 4];
  endtask

  task automatic pushIdle();
    for (int d = 0; d < 4; d++) begin
      qA[d].push_back({1'b0, lastA[d]});
      qB[d].push_back({1'b0, lastB[d]});
    end
  endtask

  task automatic step(input logic eA, input logic wA, input logic [7:0] aA, input logic [15:0] dA,
                      input logic eB, input logic wB, input logic [9:0] aB, input logic [3:0] dB);
    @(negedge clk);
    cyc++;
    checkOutputs();
    enA = eA;  weA = wA;  addrA = aA;  diA = dA;
    enB = eB;  weB = wB;  addrB = aB;  diB = dB;
    if (rst_n) modelStep();
    else       pushIdle();
  endtask

  task automatic clearExpect();
    for (int d = 0; d < 4; d++) begin
      qA[d].delete();
      qB[d].delete();
      lastA[d] = '0;
      lastB[d] = '0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    enA = 1'b0;  weA = 1'b0;  addrA = '0;  diA = '0;
    enB = 1'b0;  weB = 1'b0;  addrB = '0;  diB = '0;
    clearExpect();
    repeat (2) @(negedge clk);
    checkZero("reset");
    #1 rst_n = 1'b1;

    // Fill every word so all later reads are defined.
    for (int w = 0; w < 256; w++)
      step(1, 1, 8'(w), 16'($urandom), 0, 0, '0, '0);

    // Wide write, narrow lane reads.
    step(1, 1, 8'h12, 16'hABCD, 0, 0, '0, '0);
    step(0, 0, '0, '0, 1, 0, 10'h048, '0);
    step(0, 0, '0, '0, 1, 0, 10'h049, '0);
    step(0, 0, '0, '0, 1, 0, 10'h04A, '0);
    step(0, 0, '0, '0, 1, 0, 10'h04B, '0);
    // Narrow write into top lane, wide read back.
    step(0, 0, '0, '0, 1, 1, 10'h04B, 4'h7);
    step(1, 0, 8'h12, '0, 0, 0, '0, '0);
    // Read-during-write per mode.
    step(1, 1, 8'h05, 16'h0000, 0, 0, '0, '0);
    step(1, 1, 8'h05, 16'h1234, 0, 0, '0, '0);
    step(1, 0, 8'h05, '0, 0, 0, '0, '0);
    // Write/write collision: A wins.
    step(1, 1, 8'h12, 16'hFFFF, 1, 1, 10'h049, 4'h0);
    step(1, 0, 8'h12, '0, 0, 0, '0, '0);
    // Read vs write collision: reader sees old data.
    step(1, 1, 8'h12, 16'h7BCD, 0, 0, '0, '0);
    step(1, 0, 8'h12, '0, 1, 1, 10'h048, 4'h1);
    step(1, 0, 8'h12, '0, 0, 0, '0, '0);
    // Idle with outputs holding, then back-to-back reads.
    step(0, 0, '0, '0, 0, 0, '0, '0);
    step(0, 0, '0, '0, 0, 0, '0, '0);
    for (int i = 0; i < 4; i++) step(1, 0, 8'h12, '0, 1, 0, 10'(10'h048 + i), '0);

    // Asynchronous reset mid burst; write under reset must be discarded.
    #2 rst_n = 1'b0;
    #1 checkZero("rstAsync");
    clearExpect();
    step(1, 1, 8'h12, 16'h5555, 1, 1, 10'h049, 4'h9);
    step(0, 0, '0, '0, 0, 0, '0, '0);
    #1 rst_n = 1'b1;
    step(1, 0, 8'h12, '0, 1, 0, 10'h049, '0);
    step(1, 0, 8'h05, '0, 1, 0, 10'h048, '0);

    // Random traffic on both ports, including collisions and disabled cycles.
    for (int i = 0; i < 400; i++)
      step($urandom_range(3) != 0, $urandom_range(1) == 1, 8'($urandom), 16'($urandom),
           $urandom_range(3) != 0, $urandom_range(1) == 1,
           ($urandom_range(3) == 0) ? {addrA, 2'($urandom)} : 10'($urandom), 4'($urandom));

    repeat (3) step(0, 0, '0, '0, 0, 0, '0, '0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/asym_ram_tdp_param.md
# asym_ram_tdp_param

Parametrised asymmetric true-dual-port RAM: two independent read/write ports of different data widths share one storage array in a single clock domain. Replaces the fixed 16-bit/4-bit write-first block. Adds generic width ratio in either direction, selectable read-during-write mode, port enables, an optional output register, read-valid strobes and deterministic collision resolution. Sits between datapath producers and consumers that need width conversion through shared memory.

## Interface
- WIDTHA, 16: port A data width.
- ADDRWIDTHA, 8: port A address width.
- WIDTHB, 4: port B data width.
- ADDRWIDTHB, 10: port B address width.
- MODE, WRITE_FIRST: read-during-write behaviour, one of WRITE_FIRST, READ_FIRST, NO_CHANGE; applies to both ports.
- OUT_REG, 0: 1 adds an output pipeline register, giving 2-cycle read latency.
- Legal configurations: WIDTHA·2^ADDRWIDTHA == WIDTHB·2^ADDRWIDTHB, and the width ratio is a power of two (1 allowed). Illegal sets trigger an elaboration-time $error.
- clk  in  1  the single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- enA / enB  in  1  port enable; when low, the port does nothing and its outputs hold.
- weA / weB  in  1  write enable, qualified by en.
- addrA / addrB  in  ADDRWIDTHA / ADDRWIDTHB  word address.
- diA / diB  in  WIDTHA / WIDTHB  write data.
- doA / doB  out  WIDTHA / WIDTHB  read data.
- vldA / vldB  out  1  high in the cycle do carries data for an enabled access.

## Operation
- Storage is organised as 2^max(ADDRWIDTHA, ADDRWIDTHB) narrow words of min(WIDTHA, WIDTHB) bits. RATIO = wide width / narrow width.
- Wide address w covers narrow addresses w·RATIO+k, for k = 0..RATIO-1. Lane k maps to wide bits [k·narrow +: narrow] (little-endian lanes).
- Read data per mode when en=1 and we=1:
  - WRITE_FIRST: do = data just written.
  - READ_FIRST: do = prior contents.
  - NO_CHANGE: do holds and vld = 0.
- When en=1 and we=0, do = stored contents.
- Collision: both ports enabled, at least one writing, and the narrow-address ranges overlap.
  - Write/write: port A data wins on every overlapping lane. Non-overlapping lanes of the wide write still commit.
  - Read on one port against a write on the other: the reader gets pre-write contents on the overlapping lanes.
- Reset:
  - doA, doB, vldA and vldB go to 0 immediately; the pipeline register, if present, clears.
  - Memory contents are not reset and survive reset.
  - A write whose clock edge coincides with rst_n low is discarded.

## Timing
- OUT_REG=0: access presented at edge N; do/vld valid after edge N+1.
- OUT_REG=1: do/vld valid after edge N+2.
- vld is a single-cycle strobe per access. Back-to-back accesses give continuous vld.
- A write at edge N is visible to a read on either port issued at edge N+1.
- rst_n deassertion is synchronised by the integrator. The first access is accepted at the first edge with rst_n high.

## Configuration
- ASYM_RAM_COLLISION_DET_EN defined:
  - adds outputs collision (1 bit) and coll_cnt (16 bits);
  - collision pulses with the same latency as vld for each colliding cycle;
  - coll_cnt increments per collision, saturates at 0xFFFF, and resets to 0.
- Undefined: these ports and their logic are absent. Data behaviour is identical in both builds.

## Structure
- Package asym_ram_pkg holds:
  - the ram_mode_e enum (WRITE_FIRST, READ_FIRST, NO_CHANGE);
  - a ratio/log2 helper function;
  - a parameter-legality check function.
- Sub-module asym_ram_port_out holds the per-port mode mux, optional output register and vld pipeline. It is instantiated twice.

## Test plan
Defaults, MODE=WRITE_FIRST unless stated.
1. A writes 0x12=0xABCD; B reads 0x48, 0x49, 0x4A, 0x4B -> doB = 0xD, 0xC, 0xB, 0xA, each with vldB=1.
2. B writes 0x4B=0x7; A reads 0x12 -> doA = 0x7BCD.
3. A writes 0x05=0x1234 over 0x0000 -> doA = 0x1234 (WRITE_FIRST), 0x0000 (READ_FIRST), or held with vldA=0 (NO_CHANGE). Repeat with OUT_REG=1 and check latency 2.
4. Same edge: A writes 0x12=0xFFFF, B writes 0x49=0x0 -> subsequent read A 0x12 = 0xFFFF. With the macro: collision pulses once and coll_cnt = 1.
5. Same edge: A reads 0x12 (holding 0x7BCD) while B writes 0x48=0x1 -> doA = 0x7BCD; next read A 0x12 = 0x7BC1.
6. rst_n low mid read burst -> doA/doB/vld drop to 0 asynchronously. After release, read A 0x12 still returns its pre-reset value.
